// File: rtl/seven_seg_capture.sv
// seven_seg_capture: receive-side monitor for a multiplexed, active-low
// 7-segment bus. It synchronizes the segment and anode lines, waits for each
// digit's pattern to stay unchanged for STABLE_CYCLES samples, decodes the
// pattern back to a hex nibble and stores it in the slot chosen by the anode.
module seven_seg_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        err
);

    // Per-cycle phase of the tracker. CAPTURE is the single cycle in which
    // the current synchronized sample is the STABLE_CYCLES-th equal one.
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] TRACK   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Two-flop synchronizer stages plus the previous synchronized sample.
    logic [6:0]       seg_s1_q, seg_s2_q, seg_prev_q;
    logic [3:0]       an_s1_q, an_s2_q, an_prev_q;

    logic [1:0]       state_q, state_d, phase;
    logic [CNT_W-1:0] cnt_q, cnt_d, run;

    logic [15:0]      digits_q, digits_d;
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       mask_q, mask_d;
    logic             frame_q, frame_d;
    logic             err_q, err_d;

    logic             an_legal;
    logic             same;
    logic             capture;
    logic [1:0]       slot;
    logic [4:0]       dec;

    // Maps an active-low segment pattern (a..g on bits 6..0) to {ok, nibble}.
    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // True when exactly one anode line is driven low.
    function automatic logic one_hot_low(input logic [3:0] a);
        return (a == 4'b1110) || (a == 4'b1101) ||
               (a == 4'b1011) || (a == 4'b0111);
    endfunction

    // Digit position selected by a legal anode pattern.
    function automatic logic [1:0] anode_slot(input logic [3:0] a);
        logic [1:0] s;
        case (a)
            4'b1101: s = 2'd1;
            4'b1011: s = 2'd2;
            4'b0111: s = 2'd3;
            default: s = 2'd0;
        endcase
        return s;
    endfunction

    assign an_legal = one_hot_low(an_s2_q);
    assign same     = (seg_s2_q == seg_prev_q) && (an_s2_q == an_prev_q);
    assign slot     = anode_slot(an_s2_q);
    assign dec      = decode_seg(seg_s2_q);

    // Synchronize the raw bus and remember the previous synchronized sample;
    // reset to an idle bus (all lines high) so the first real sample is new.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_q   <= 7'h7F;
            seg_s2_q   <= 7'h7F;
            seg_prev_q <= 7'h7F;
            an_s1_q    <= 4'hF;
            an_s2_q    <= 4'hF;
            an_prev_q  <= 4'hF;
        end else begin
            seg_s1_q   <= seg;
            seg_s2_q   <= seg_s1_q;
            seg_prev_q <= seg_s2_q;
            an_s1_q    <= an;
            an_s2_q    <= an_s1_q;
            an_prev_q  <= an_s2_q;
        end
    end

    // Stability tracking: counter holds (equal samples - 1) of the current run.
    always_comb begin
        run   = '0;
        phase = IDLE;
        if (!an_legal) begin
            phase = IDLE;
        end else if (state_q == HOLD && same) begin
            phase = HOLD;
        end else begin
            run   = (state_q == TRACK && same) ? cnt_q + CNT_W'(1) : '0;
            phase = (run == CNT_LAST) ? CAPTURE : TRACK;
        end
    end

    // Next FSM state and counter; a capture always parks the tracker in HOLD.
    always_comb begin
        capture = (phase == CAPTURE);
        state_d = capture ? HOLD : phase;
        cnt_d   = (phase == TRACK) ? run : '0;
    end

    // Slot update, error pulse and frame bookkeeping for a capture cycle.
    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        frame_d  = (mask_q == 4'hF);
        mask_d   = frame_d ? 4'h0 : mask_q;
        if (capture) begin
            if (dec[4]) begin
                digits_d[{slot, 2'b00} +: 4] = dec[3:0];
                valid_d[slot]                = 1'b1;
                mask_d[slot]                 = 1'b1;
            end else begin
                valid_d[slot] = 1'b0;
                err_d         = 1'b1;
            end
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            mask_q   <= '0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            mask_q   <= mask_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_q;
    assign err         = err_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: directed scenarios plus a
// randomized phase, checked every cycle against a run-length reference model.
module tb_seven_seg_capture;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an  = 4'hF;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        err;

    int checks = 0;
    int failures = 0;
    int frame_cnt = 0;
    int err_cnt = 0;

    logic [6:0] TBL [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    seven_seg_capture #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .seg(seg), .an(an),
        .digits(digits), .digit_valid(digit_valid),
        .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] tb_decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (TBL[i] == p) return {1'b1, 4'(i)};
        return 5'b0;
    endfunction

    // ---------------- reference model ----------------
    // A digit is captured exactly when the twice-delayed sample has shown
    // the same legal (an, seg) pair for S consecutive cycles.
    logic [3:0]  m_d1an, m_d2an, m_pan;
    logic [6:0]  m_d1seg, m_d2seg, m_pseg;
    int          m_run;
    logic [15:0] m_digits;
    logic [3:0]  m_valid, m_mask;
    logic        m_frame, m_err;
    int          m_slot;
    logic [4:0]  m_dec;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_d1an = 4'hF; m_d2an = 4'hF; m_pan = 4'hF;
            m_d1seg = 7'h7F; m_d2seg = 7'h7F; m_pseg = 7'h7F;
            m_run = 0; m_digits = '0; m_valid = '0; m_mask = '0;
            m_frame = 1'b0; m_err = 1'b0;
        end else begin
            if ($countones(~m_d2an) != 1) m_run = 0;
            else if (m_d2an == m_pan && m_d2seg == m_pseg) m_run = m_run + 1;
            else m_run = 1;
            m_frame = (m_mask == 4'hF);
            if (m_frame) m_mask = 4'h0;
            m_err = 1'b0;
            if (m_run == S) begin
                m_slot = 0;
                for (int k = 0; k < 4; k++) if (!m_d2an[k]) m_slot = k;
                m_dec = tb_decode(m_d2seg);
                if (m_dec[4]) begin
                    m_digits[m_slot*4 +: 4] = m_dec[3:0];
                    m_valid[m_slot] = 1'b1;
                    m_mask[m_slot] = 1'b1;
                end else begin
                    m_valid[m_slot] = 1'b0;
                    m_err = 1'b1;
                end
            end
            m_pan = m_d2an; m_pseg = m_d2seg;
            m_d2an = m_d1an; m_d2seg = m_d1seg;
            m_d1an = an; m_d1seg = seg;
        end
    end

    // Every-cycle comparison against the model, plus pulse counters.
    always @(negedge clk) begin
        chk("digits", 32'(digits), 32'(m_digits));
        chk("digit_valid", 32'(digit_valid), 32'(m_valid));
        chk("frame_done", 32'(frame_done), 32'(m_frame));
        chk("err", 32'(err), 32'(m_err));
        if (frame_done) frame_cnt++;
        if (err) err_cnt++;
    end

    // Advance n clock edges and return 2 time units after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic setin(input logic [3:0] a, input logic [6:0] s);
        an = a;
        seg = s;
    endtask

    logic [15:0] snap_d;
    logic [3:0]  snap_v;
    int          e0, f0, idx, last_idx, holdn;
    logic [3:0]  ra;
    logic [6:0]  rs;

    initial begin
        // Reset with a digit already on the bus
        setin(4'b1110, TBL[1]);
        @(posedge clk); #2;
        step(2);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_valid", 32'(digit_valid), 32'h0);
        chk("rst_frame", 32'(frame_done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst = 1'b0;
        step(S + 1);
        chk("lat_early_valid", 32'(digit_valid), 32'h0);
        step(1);
        chk("lat_digit0", 32'(digits[3:0]), 32'h1);
        chk("lat_valid", 32'(digit_valid), 32'h1);
        chk("lat_no_frame", 32'(frame_cnt), 32'h0);

        // Full frame 0,1,2,F
        f0 = frame_cnt;
        setin(4'b1110, TBL[0]);  step(10);
        setin(4'b1101, TBL[1]);  step(10);
        setin(4'b1011, TBL[2]);  step(10);
        setin(4'b0111, TBL[15]); step(10);
        chk("frame_digits", 32'(digits), 32'hF210);
        chk("frame_valid", 32'(digit_valid), 32'hF);
        chk("frame_pulses", 32'(frame_cnt - f0), 32'h1);

        // Glitch rejection: pattern changes every 3 cycles
        e0 = err_cnt;
        snap_d = digits;
        last_idx = 0;
        for (int g = 0; g < 8; g++) begin
            do idx = $urandom_range(1, 15); while (idx == last_idx);
            last_idx = idx;
            setin(4'b1110, TBL[idx]);
            step(3);
        end
        chk("glitch_digits", 32'(digits), 32'(snap_d));
        chk("glitch_err", 32'(err_cnt - e0), 32'h0);
        setin(4'b1110, 7'b0001000);
        step(S + 2);
        chk("glitch_then_A", 32'(digits[3:0]), 32'hA);

        // Bad pattern on slot 1
        setin(4'b1101, TBL[2]); step(8);
        e0 = err_cnt;
        setin(4'b1101, 7'b1111111); step(20);
        chk("bad_err_once", 32'(err_cnt - e0), 32'h1);
        chk("bad_valid1", 32'(digit_valid[1]), 32'h0);
        chk("bad_slot1", 32'(digits[7:4]), 32'h2);

        // Illegal anodes, then a legal one with exact latency
        snap_d = digits; snap_v = digit_valid; e0 = err_cnt;
        setin(4'b1100, TBL[5]); step(20);
        setin(4'b1111, TBL[5]); step(20);
        chk("illegal_digits", 32'(digits), 32'(snap_d));
        chk("illegal_valid", 32'(digit_valid), 32'(snap_v));
        chk("illegal_err", 32'(err_cnt - e0), 32'h0);
        setin(4'b1011, TBL[7]);
        step(S + 1);
        chk("an2_early", 32'(digits[11:8]), 32'h2);
        step(1);
        chk("an2_digit", 32'(digits[11:8]), 32'h7);
        chk("an2_valid", 32'(digit_valid[2]), 32'h1);

        // Randomized traffic
        for (int r = 0; r < 250; r++) begin
            if ($urandom_range(0, 3) != 0) ra = ~(4'b0001 << $urandom_range(0, 3));
            else ra = 4'($urandom);
            case ($urandom_range(0, 9))
                0:       rs = 7'h7F;
                1, 2:    rs = 7'($urandom);
                default: rs = TBL[$urandom_range(0, 15)];
            endcase
            holdn = $urandom_range(1, 8);
            setin(ra, rs);
            step(holdn);
        end

        // Asynchronous reset two cycles into stability
        setin(4'b1111, 7'h7F); step(S + 4);
        setin(4'b1110, TBL[3]); step(2);
        setin(4'b1110, TBL[3]); step(1);
        #1 rst = 1'b1;
        #1;
        chk("arst_digits", 32'(digits), 32'h0);
        chk("arst_valid", 32'(digit_valid), 32'h0);
        chk("arst_err", 32'(err), 32'h0);
        setin(4'b1111, 7'h7F);
        step(3);
        rst = 1'b0;
        step(S + 4);
        chk("arst_no_capture", 32'(digit_valid), 32'h0);
        chk("arst_digits_after", 32'(digits), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Receive-side monitor for the multiplexed Basys3 7-segment bus.
- Samples the active-low segment lines and active-low anode lines, and waits for each digit's pattern to hold steady.
- Decodes each stable pattern back to a 4-bit hex value per digit position.
- Used for on-board self-check and loopback of the display path: it recovers the number the display driver is showing.

Parameters:
- STABLE_CYCLES, 4: consecutive cycles that seg and an must hold unchanged before a capture; legal range 1..255.
- CNT_W, 8: width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- seg  input  7  segment lines, active-low; seg[6]=a … seg[0]=g.
- an  input  4  anode lines, active-low; legal when exactly one bit is 0.
- digits  output  16  captured nibbles; digits[4i+3:4i] is the digit for anode i.
- digit_valid  output  4  bit i is set when digits slot i holds a decoded value.
- frame_done  output  1  one-cycle pulse once all 4 slots have been captured since the last pulse or reset.
- err  output  1  one-cycle pulse when a stable pattern is not in the decode table.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: digits=0, digit_valid=0, frame_done=0, err=0, FSM=IDLE, counter=0, frame-seen mask=0. Reset mid-capture discards all partial state.
- Inputs pass through a 2-flop synchronizer before use. All latencies below are counted from the synchronized values.
- Decode table (seg pattern → value):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3
  - 0100100... see full list: 1001100→4, 0100100→5, 0100000→6, 0001111→7
  - 0000000→8, 0000100→9, 0001000→A, 1100000→b
  - 0110001→C, 1000010→d, 0110000→E, 0111000→F
  - Any other pattern, including blank 1111111, is undecodable.
- FSM states:
  - IDLE: an is not one-hot-low (all high, or 2+ low). Counter is held at 0.
  - TRACK: an is legal. The counter increments each cycle that seg and an equal their previous sampled value. Any change resets the counter to 0; an illegal an returns the FSM to IDLE.
  - CAPTURE: entered when counter reaches STABLE_CYCLES−1, i.e. STABLE_CYCLES equal samples. Lasts exactly one cycle:
    - Decodable pattern: write the nibble to slot i, set digit_valid[i], set mask[i].
    - Undecodable pattern: pulse err, clear digit_valid[i], leave slot value unchanged, do not set mask.
  - HOLD: stays here while seg and an are unchanged, with no re-capture and no repeated err. Any change goes to TRACK with counter 0, or to IDLE if an is illegal.
- Capture latency: digits and digit_valid update on the clock edge that ends CAPTURE, which is STABLE_CYCLES+2 edges after the raw inputs settle (the 2-flop synchronizer included).
- frame_done:
  - Pulses the cycle after mask becomes 4'b1111; mask then clears to 0.
  - A re-capture of an already-set slot before the mask is full updates the slot but does not count twice.
  - A capture that completes the mask in the same cycle it is cleared is not possible, because the mask clears only on the pulse.
- Glitch rule: a pattern held for fewer than STABLE_CYCLES cycles is never captured and never raises err.
- Values held in digits persist indefinitely; there is no timeout.

Test Plan:
- Reset: assert rst with an=1110 and seg=1001111 held → all outputs 0. Release rst → after STABLE_CYCLES+2 edges, digits[3:0]=1 and digit_valid=0001, with no frame_done.
- Full frame: scan an through 1110, 1101, 1011, 0111, each for 10 cycles, with patterns for 0, 1, 2, F → digits=16'hF210, digit_valid=1111, exactly one frame_done pulse after the last capture.
- Glitch rejection (STABLE_CYCLES=4): change seg on an=1110 every 3 cycles → no capture and no err. Then hold 0001000 → digits[3:0]=A.
- Bad pattern: on an=1101 with slot 1 already holding 2, hold seg=1111111 → single err pulse, digit_valid[1]=0, slot 1 still 2, no repeat while the pattern holds.
- Illegal anode: an=1100 or 1111 with a valid seg held for 20 cycles → no state change. Then an=1011 → capture after STABLE_CYCLES+2 edges.
- Async reset mid-TRACK: assert rst two cycles into stability → outputs clear immediately, without waiting for a clk edge, and no capture occurs.
